// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard.
// The stage entry is sized for up to 256 registers and 15 tracked stages.
// Narrower design parameters are zero-extended into these fields.
package hazard_pkg;

  localparam int FWD_RF   = 0;
  localparam int RDY_ALU  = 1;
  localparam int RDY_LOAD = 2;

  localparam int HZ_RD_W  = 8;
  localparam int HZ_SEL_W = 4;

  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic [HZ_RD_W-1:0]  rd;
    logic [HZ_SEL_W-1:0] rdy_stage;
  } hz_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side bundle of the hazard scoreboard.
// master: the ID stage and pipeline control.
// slave:  the scoreboard.
interface hazard_scoreboard_if #(
  parameter int NREGS  = 32,
  parameter int NSTAGE = 2,
  parameter int NSRC   = 2
);
  localparam int REG_W = $clog2(NREGS);
  localparam int SEL_W = $clog2(NSTAGE + 1);

  logic                    id_valid;
  logic                    id_regwrite;
  logic [REG_W-1:0]        id_rd;
  logic [SEL_W-1:0]        id_rdy_stage;
  logic [NSRC*REG_W-1:0]   id_rs;
  logic [NSRC-1:0]         id_rs_used;
  logic                    hold;
  logic                    flush;
  logic                    stall;
  logic [NSRC*SEL_W-1:0]   fwd_sel;
  logic [31:0]             stall_cnt;

  modport master (
    output id_valid, id_regwrite, id_rd, id_rdy_stage, id_rs, id_rs_used, hold, flush,
    input  stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_regwrite, id_rd, id_rdy_stage, id_rs, id_rs_used, hold, flush,
    output stall, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: priority matcher for one source operand against all tracked
// stages. The youngest (lowest-numbered) writer of the register wins; if that
// writer has not reached its ready stage the source is a hazard instead.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NSTAGE = 2,
  parameter int REG_W  = 5,
  parameter int SEL_W  = 2
) (
  input  logic             en,
  input  logic [REG_W-1:0] rs,
  input  hz_entry_t        stages [1:NSTAGE],
  output logic [SEL_W-1:0] sel,
  output logic             hazard
);

  // Scan from stage 1 upward; the first hit blocks all older stages.
  always_comb begin
    logic found;
    found  = 1'b0;
    sel    = SEL_W'(FWD_RF);
    hazard = 1'b0;
    if (en && rs != '0) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        if (!found && stages[k].valid && stages[k].regwrite &&
            stages[k].rd == HZ_RD_W'(rs)) begin
          found = 1'b1;
          if (HZ_SEL_W'(k) >= stages[k].rdy_stage)
            sel = SEL_W'(k);
          else
            hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destinations of in-flight instructions, resolves
// operand forwarding for the ID instruction and stalls on not-yet-ready results.
// Optional feature: define HAZARD_PERF_EN to build the saturating stall_cnt
// counter; otherwise stall_cnt is tied to zero.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NSTAGE = 2,
  parameter int NSRC   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);

  localparam int REG_W = $clog2(NREGS);
  localparam int SEL_W = $clog2(NSTAGE + 1);

  hz_entry_t        stage_q [1:NSTAGE];
  hz_entry_t        id_entry;
  logic [NSRC-1:0]  src_hazard;
  logic [SEL_W-1:0] sel_arr [NSRC];
  logic [SEL_W-1:0] rdy_clamped;
  logic             stall_int;

  // Out-of-range ready stages: 0 behaves as ALU, beyond the pipe as last stage.
  always_comb begin
    rdy_clamped = bus.id_rdy_stage;
    if (bus.id_rdy_stage == '0)
      rdy_clamped = SEL_W'(RDY_ALU);
    else if (bus.id_rdy_stage > SEL_W'(NSTAGE))
      rdy_clamped = SEL_W'(NSTAGE);
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    hazard_match #(
      .NSTAGE (NSTAGE),
      .REG_W  (REG_W),
      .SEL_W  (SEL_W)
    ) u_match (
      .en     (bus.id_valid && bus.id_rs_used[g]),
      .rs     (bus.id_rs[g*REG_W +: REG_W]),
      .stages (stage_q),
      .sel    (sel_arr[g]),
      .hazard (src_hazard[g])
    );
  end

  // Pack per-source selects onto the bus.
  always_comb begin
    bus.fwd_sel = '0;
    for (int i = 0; i < NSRC; i++)
      bus.fwd_sel[i*SEL_W +: SEL_W] = sel_arr[i];
  end

  // Flush and hold both override a hazard.
  assign stall_int = (|src_hazard) && !bus.flush && !bus.hold;
  assign bus.stall = stall_int;

  // Entry presented to stage 1; a stalled or flushed instruction becomes a bubble.
  always_comb begin
    id_entry           = '0;
    id_entry.valid     = bus.id_valid && !stall_int && !bus.flush;
    id_entry.regwrite  = bus.id_regwrite;
    id_entry.rd        = HZ_RD_W'(bus.id_rd);
    id_entry.rdy_stage = HZ_SEL_W'(rdy_clamped);
  end

  // Stage shift register; frozen while hold is asserted, last stage retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= NSTAGE; k++)
        stage_q[k] <= '0;
    end else if (!bus.hold) begin
      for (int k = NSTAGE; k >= 2; k--)
        stage_q[k] <= stage_q[k-1];
      stage_q[1] <= id_entry;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of stall cycles, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall_int && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, reset
// corner cases, then randomized traffic against a queue-based reference model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NSTAGE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;

  hazard_scoreboard_if #(.NREGS(32), .NSTAGE(NSTAGE), .NSRC(2)) bus ();

  hazard_scoreboard #(.NREGS(32), .NSTAGE(NSTAGE), .NSRC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       hold, flush, valid, rw;
    int       rd, rdy, rs0, rs1;
    bit [1:0] used;
    bit       e_stall;
    int       e_sel0, e_sel1;
  } vec_t;

  typedef struct {
    bit valid;
    bit rw;
    int rd;
    int rdy;
  } m_ent_t;

  vec_t   vecs[$];
  m_ent_t mq[$];

  function automatic vec_t mk(bit h, bit f, bit v, bit rw, int rd, int rdy,
                              int rs0, int rs1, bit [1:0] used,
                              bit e_stall, int e_sel0, int e_sel1);
    vec_t r;
    r.hold = h; r.flush = f; r.valid = v; r.rw = rw;
    r.rd = rd; r.rdy = rdy; r.rs0 = rs0; r.rs1 = rs1; r.used = used;
    r.e_stall = e_stall; r.e_sel0 = e_sel0; r.e_sel1 = e_sel1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input bit h, input bit f, input bit v, input bit rw, input int rd,
                       input int rdy, input int rs0, input int rs1, input bit [1:0] used);
    bus.hold         = h;
    bus.flush        = f;
    bus.id_valid     = v;
    bus.id_regwrite  = rw;
    bus.id_rd        = 5'(rd);
    bus.id_rdy_stage = 2'(rdy);
    bus.id_rs        = {5'(rs1), 5'(rs0)};
    bus.id_rs_used   = used;
  endtask

  function automatic int exp_stall_cnt();
`ifdef HAZARD_PERF_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  initial begin
    bit h, f, v, rw, hz, e_stall;
    int rd, rdy, rdy_cl, rs0, rs1, rs;
    bit [1:0] used;
    int e_sel [2];

    drive(0, 0, 0, 0, 0, RDY_ALU, 1, 2, 2'b11);
    #12;
    check("reset_stall", 32'(bus.stall), 0);
    check("reset_fwd_sel", 32'(bus.fwd_sel), 0);
    check("reset_stall_cnt", bus.stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: one row per cycle, expectations checked before the edge.
    vecs.push_back(mk(0,0,1,0, 0,1,        1, 2,2'b11, 0,0,0));
    vecs.push_back(mk(0,0,1,1, 5,RDY_ALU,  1, 2,2'b11, 0,0,0));
    vecs.push_back(mk(0,0,1,0, 0,1,        5, 0,2'b01, 0,1,0));
    vecs.push_back(mk(0,0,1,0, 0,1,        0, 5,2'b10, 0,0,2));
    vecs.push_back(mk(0,0,1,0, 0,1,        5, 5,2'b11, 0,0,0));
    vecs.push_back(mk(0,0,1,1, 7,RDY_LOAD, 0, 0,2'b00, 0,0,0));
    vecs.push_back(mk(0,0,1,0, 0,1,        7, 0,2'b01, 1,0,0));
    vecs.push_back(mk(0,0,1,0, 0,1,        7, 0,2'b01, 0,2,0));
    vecs.push_back(mk(0,0,1,1, 6,RDY_ALU,  0, 0,2'b00, 0,0,0));
    vecs.push_back(mk(0,0,1,1, 6,RDY_ALU,  6, 0,2'b01, 0,1,0));
    vecs.push_back(mk(0,0,1,0, 0,1,        6, 0,2'b01, 0,1,0));
    vecs.push_back(mk(0,0,1,1, 0,RDY_ALU,  0, 0,2'b00, 0,0,0));
    vecs.push_back(mk(0,0,1,1, 3,RDY_ALU,  0, 0,2'b01, 0,0,0));
    vecs.push_back(mk(0,0,1,0, 0,1,        0, 3,2'b01, 0,0,0));
    vecs.push_back(mk(0,0,1,1, 9,RDY_LOAD, 0, 0,2'b00, 0,0,0));
    vecs.push_back(mk(1,0,1,0, 0,1,        9, 0,2'b01, 0,0,0));
    vecs.push_back(mk(1,0,1,0, 0,1,        9, 0,2'b01, 0,0,0));
    vecs.push_back(mk(1,0,1,0, 0,1,        9, 0,2'b01, 0,0,0));
    vecs.push_back(mk(0,0,1,0, 0,1,        9, 0,2'b01, 1,0,0));
    vecs.push_back(mk(0,0,1,0, 0,1,        9, 0,2'b01, 0,2,0));
    vecs.push_back(mk(0,0,1,1, 4,RDY_LOAD, 0, 0,2'b00, 0,0,0));
    vecs.push_back(mk(0,1,1,1, 8,RDY_ALU,  4, 0,2'b01, 0,0,0));
    vecs.push_back(mk(0,0,1,0, 0,1,        8, 4,2'b11, 0,0,2));
    vecs.push_back(mk(0,0,1,1,10,0,        0, 0,2'b00, 0,0,0));
    vecs.push_back(mk(0,0,1,1,11,3,       10, 0,2'b01, 0,1,0));
    vecs.push_back(mk(0,0,1,0, 0,1,       11, 0,2'b01, 1,0,0));
    vecs.push_back(mk(0,0,1,0, 0,1,       11, 0,2'b01, 0,2,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].hold, vecs[i].flush, vecs[i].valid, vecs[i].rw, vecs[i].rd,
            vecs[i].rdy, vecs[i].rs0, vecs[i].rs1, vecs[i].used);
      #1;
      check($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_sel0", i), 32'(bus.fwd_sel[1:0]), 32'(vecs[i].e_sel0));
      check($sformatf("vec%0d_sel1", i), 32'(bus.fwd_sel[3:2]), 32'(vecs[i].e_sel1));
      if (vecs[i].e_stall) exp_cnt++;
      @(negedge clk);
    end
    check("table_stall_cnt", bus.stall_cnt, 32'(exp_stall_cnt()));

    // Asynchronous reset in the middle of a load-use stall.
    drive(0, 0, 1, 1, 7, RDY_LOAD, 0, 0, 2'b00);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 1, 7, 0, 2'b01);
    #1;
    check("midstall_stall_before", 32'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    check("midstall_rst_stall", 32'(bus.stall), 0);
    check("midstall_rst_fwd_sel", 32'(bus.fwd_sel), 0);
    check("midstall_rst_stall_cnt", bus.stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_stall", 32'(bus.stall), 0);
    @(negedge clk);

    // Randomized traffic against a queue of in-flight writers, index = stage-1.
    exp_cnt = 0;
    mq.delete();
    for (int k = 0; k < NSTAGE; k++) mq.push_back('{valid: 1'b0, rw: 1'b0, rd: 0, rdy: 1});
    for (int c = 0; c < 400; c++) begin
      h    = ($urandom_range(0, 7) == 0);
      f    = ($urandom_range(0, 7) == 0);
      v    = ($urandom_range(0, 7) != 0);
      rw   = 1'($urandom_range(0, 1));
      rd   = $urandom_range(0, 7);
      rdy  = $urandom_range(0, 3);
      rs0  = $urandom_range(0, 7);
      rs1  = $urandom_range(0, 7);
      used = 2'($urandom_range(0, 3));
      rdy_cl = (rdy == 0) ? 1 : ((rdy > NSTAGE) ? NSTAGE : rdy);

      hz = 1'b0;
      for (int s = 0; s < 2; s++) begin
        rs = (s == 0) ? rs0 : rs1;
        e_sel[s] = 0;
        if (v && used[s] && rs != 0) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].valid && mq[i].rw && mq[i].rd == rs) begin
              if (i + 1 >= mq[i].rdy) e_sel[s] = i + 1;
              else hz = 1'b1;
              break;
            end
          end
        end
      end
      e_stall = hz && !f && !h;

      drive(h, f, v, rw, rd, rdy, rs0, rs1, used);
      #1;
      check($sformatf("rnd%0d_stall", c), 32'(bus.stall), 32'(e_stall));
      check($sformatf("rnd%0d_sel0", c), 32'(bus.fwd_sel[1:0]), 32'(e_sel[0]));
      check($sformatf("rnd%0d_sel1", c), 32'(bus.fwd_sel[3:2]), 32'(e_sel[1]));
      if (e_stall) exp_cnt++;
      if (!h) begin
        mq.push_front('{valid: v && !e_stall && !f, rw: rw, rd: rd, rdy: rdy_cl});
        void'(mq.pop_back());
      end
      @(negedge clk);
    end
    check("random_stall_cnt", bus.stall_cnt, 32'(exp_stall_cnt()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
